// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Used by the top module and its fetch buffer.
package instruction_fetch_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        WAIT,
        RUN,
        PAUSE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_sequencer_fifo.sv
// Fetch buffer: registered storage with sync push/pop, flush and count.
// Head is read straight from storage so it holds steady under stall.
module fetch_fifo
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: PC, FSM, issue/in-flight tracking, redirect.
// Optional FETCH_PERF_COUNTERS_EN adds fetch/stall/flush counters.
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] PC_INCREMENT = 32'd1,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flushes
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    state_t        state_next;
    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    logic          empty;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          pop;
    logic          push;
    logic          redirect;
    logic          issue;
    logic          run;
    logic [CW:0]   occupancy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            WAIT:    state_next = fetch_enable ? RUN : PAUSE;
            RUN:     state_next = fetch_enable ? RUN : PAUSE;
            PAUSE:   state_next = fetch_enable ? RUN : PAUSE;
            default: state_next = WAIT;
        endcase
    end

    always_comb begin
        run          = (state == RUN);
        redirect     = branch_valid && (state != WAIT);
        fetch_valid  = !empty;
        imem_address = pc;
    end

    assign pop = fetch_valid && fetch_ready;

    // Count the in-flight word as occupied so a full buffer never overflows.
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign issue     = run && !branch_valid
                    && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign push      = inflight && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (redirect) begin
                pc <= branch_target;
            end else if (issue) begin
                pc          <= pc + PC_INCREMENT;
                inflight_pc <= pc;
            end
        end
    end

    assign push_data.pc    = inflight_pc;
    assign push_data.instr = imem_instruction;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    assign fetch_instruction = head.instr;
    assign fetch_pc          = head.pc;

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (fetch_valid && !fetch_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (branch_valid) begin
                perf_flushes <= perf_flushes + 16'd1;
            end
        end
    end
`endif

endmodule
